radix4_mul_seq: RTL and testbench
=================================

Name: radix4_mul_seq

Overview:
- Sequencing controller that reuses one shared radix-4 partial-product unit (A_W-bit operand times 2-bit digit, registered) to compute a full A_W x B_W unsigned product.
- Accepts an operand pair over a valid/ready handshake and issues one 2-bit digit of B per cycle, LSB digit first.
- Shift-accumulates the returned partial products and presents the product over a valid/ready response handshake.
- Sits between the multiplier's request front end and the partial-product datapath.

Parameters:
- A_W, 8, multiplicand width (even, >=4).
- B_W, 8, multiplier width (even, >=2); NUM_DIG = B_W/2.
- PP_LAT, 1, partial-product unit latency in cycles (0..3); the unit returns pp_i exactly PP_LAT cycles after the digit is driven.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  operand pair valid.
- req_ready_o  out  1  block can accept operands.
- req_a_i  in  A_W  multiplicand.
- req_b_i  in  B_W  multiplier.
- pp_a_o  out  A_W  multiplicand driven to the partial-product unit.
- pp_b_o  out  2  current B digit driven to the partial-product unit.
- pp_issue_o  out  1  a digit is issued this cycle.
- pp_i  in  A_W+2  unsigned partial product (pp_a_o * pp_b_o) returned PP_LAT cycles after issue.
- rsp_valid_o  out  1  product valid.
- rsp_ready_i  in  1  consumer accepts product.
- rsp_prod_o  out  A_W+B_W  unsigned product.
- busy_o  out  1  high in ISSUE or DRAIN.

Behaviour:
- Interface: one clock (clk_i); synchronous, active-high reset (rst_i). On reset: state=IDLE, req_ready_o=1, rsp_valid_o=0, pp_issue_o=0, busy_o=0, pp_a_o=0, pp_b_o=0, rsp_prod_o=0, accumulator=0, all counters=0.
- Reset asserted mid-operation aborts the operation. Any returns still in flight are discarded: the return tracker is cleared by reset and ignores pp_i.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: req_ready_o=1. On req_valid_i && req_ready_o:
  - latch A into a_q and B into b_q.
  - clear the accumulator.
  - set issue_cnt=0 and ret_cnt=0.
  - go to ISSUE.
- ISSUE: pp_issue_o=1, pp_a_o=a_q, pp_b_o=b_q[2*issue_cnt+1 : 2*issue_cnt]. issue_cnt increments every cycle. After digit NUM_DIG-1 is issued:
  - go to DRAIN if PP_LAT>0.
  - else go to DONE.
- Return tracking: a PP_LAT-deep valid shift register follows pp_issue_o.
  - When its output is 1: acc <= acc + (pp_i zero-extended << 2*ret_cnt), then ret_cnt++.
  - With PP_LAT=0, pp_i is sampled combinationally in the issue cycle.
- DRAIN: pp_issue_o=0. Go to DONE in the cycle the last return (ret_cnt==NUM_DIG-1) is accumulated.
- Accumulator width: A_W+B_W, no overflow possible. The final partial product's carry-out above bit A_W+B_W-1 is provably zero and is dropped.
- DONE: rsp_valid_o=1, rsp_prod_o=acc. Both are held stable until rsp_ready_i. On handshake, go to IDLE.
- req_ready_o=1 only in IDLE (no overlap of operations). Requests arriving while not ready are ignored; there is no queuing.
- Latency: acceptance to rsp_valid_o = NUM_DIG+PP_LAT cycles (defaults: 5).
- Simultaneous rsp handshake and new req_valid_i in DONE: the new request is not accepted until the following IDLE cycle, so throughput is one op per NUM_DIG+PP_LAT+1 cycles minimum.
- Zero operands still take the full cycle count; there is no early termination.
- Digit 0 of B equal to 0: pp_issue_o still asserts; the unit is always exercised deterministically.

Optional Feature:
- Macro RADIX4_MUL_PERF_CNT_EN.
- Defined:
  - adds output perf_ops_o [31:0], the count of completed response handshakes.
  - adds output perf_stall_o [31:0], the count of DONE cycles with rsp_ready_i=0.
  - both counters wrap at 2^32 and reset to 0 on rst_i.
- Undefined: both ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package radix4_mul_pkg:
  - state enum typedef (IDLE/ISSUE/DRAIN/DONE).
  - localparams DIG_W=2 and default A_W/B_W.
  - function digit_sel(b, idx) returning the 2-bit slice.
- Sub-module radix4_ret_tracker: the PP_LAT-deep valid delay line plus ret_cnt, outputting ret_valid and ret_idx. It is kept separate so PP_LAT=0 bypass is isolated.
- FSM and accumulator stay in radix4_mul_seq.

Test Plan:
- A=8'hFF, B=8'hFF, PP_LAT=1, rsp_ready_i=1: rsp_prod_o=16'hFE01 exactly 5 cycles after acceptance; pp_b_o sequence 3,3,3,3.
- A=8'd13, B=8'b10_01_11_00 (8'h9C) → pp_b_o sequence 0,3,1,2 on consecutive issue cycles; rsp_prod_o=16'd2028.
- A=8'h00 or B=8'h00 → product 0 after full latency; pp_issue_o high for 4 cycles.
- Backpressure: hold rsp_ready_i=0 for 7 cycles in DONE with req_valid_i=1 → rsp_prod_o stable, req_ready_o=0, no new acceptance; release → IDLE next cycle, the next request is accepted one cycle later.
- Assert rst_i during ISSUE cycle 2 → next cycle IDLE, all outputs at reset values; a fresh request A=3, B=5 then yields 15 with no corruption from the aborted returns.
- With RADIX4_MUL_PERF_CNT_EN: 3 ops, the second stalled 4 cycles → perf_ops_o=3, perf_stall_o=4.
- Random sweep at PP_LAT=0,1,3 against a reference model.

Source files
------------

// File: rtl/radix4_mul_pkg.sv
// Shared types and helpers for the radix-4 sequential multiplier.
package radix4_mul_pkg;

  localparam int DIG_W   = 2;
  localparam int DEF_A_W = 8;
  localparam int DEF_B_W = 8;
  localparam int MAX_B_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Callers zero-extend their multiplier to MAX_B_W before selecting a digit.
  function automatic logic [DIG_W-1:0] digit_sel(input logic [MAX_B_W-1:0] b, input int idx);
    return b[DIG_W*idx +: DIG_W];
  endfunction

endpackage

// File: rtl/radix4_ret_tracker.sv
// Tracks partial-product returns: PP_LAT-deep valid delay line behind the issue strobe,
// plus the index of the digit whose product is currently returning.
module radix4_ret_tracker
  import radix4_mul_pkg::*;
#(
  parameter int PP_LAT = 1,
  parameter int CNT_W  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  input  logic             start_i,
  output logic             ret_valid_o,
  output logic [CNT_W-1:0] ret_idx_o
);

  logic [CNT_W-1:0] ret_cnt_q;

  generate
    if (PP_LAT == 0) begin : g_bypass
      // Unit is combinational: the product comes back in the issue cycle.
      assign ret_valid_o = issue_i;
    end else begin : g_delay
      logic [PP_LAT-1:0] vld_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= issue_i;
          for (int i = 1; i < PP_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      assign ret_valid_o = vld_q[PP_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ret_cnt_q <= '0;
    end else if (start_i) begin
      ret_cnt_q <= '0;
    end else if (ret_valid_o) begin
      ret_cnt_q <= ret_cnt_q + 1'b1;
    end
  end

  assign ret_idx_o = ret_cnt_q;

endmodule

// File: rtl/radix4_mul_seq.sv
// Sequencer driving a shared radix-4 partial-product unit to form an A_W x B_W product.
// Optional perf counters (perf_ops_o, perf_stall_o) under RADIX4_MUL_PERF_CNT_EN.
//
// state    | meaning
// ST_IDLE  | ready for an operand pair
// ST_ISSUE | one B digit per cycle to the partial-product unit, LSB first
// ST_DRAIN | waiting for the remaining in-flight partial products
// ST_DONE  | product held on rsp_prod_o until rsp_ready_i
module radix4_mul_seq
  import radix4_mul_pkg::*;
#(
  parameter int A_W    = DEF_A_W,
  parameter int B_W    = DEF_B_W,
  parameter int PP_LAT = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [A_W-1:0]     req_a_i,
  input  logic [B_W-1:0]     req_b_i,
  output logic [A_W-1:0]     pp_a_o,
  output logic [DIG_W-1:0]   pp_b_o,
  output logic               pp_issue_o,
  input  logic [A_W+1:0]     pp_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [A_W+B_W-1:0] rsp_prod_o,
  output logic               busy_o
`ifdef RADIX4_MUL_PERF_CNT_EN
  ,
  output logic [31:0]        perf_ops_o,
  output logic [31:0]        perf_stall_o
`endif
);

  localparam int NUM_DIG = B_W / DIG_W;
  localparam int PROD_W  = A_W + B_W;
  localparam int CNT_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NUM_DIG - 1);

  state_t            state_q, state_d;
  logic [A_W-1:0]    a_q;
  logic [B_W-1:0]    b_q;
  logic [PROD_W-1:0] acc_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic              accept;
  logic              ret_valid;
  logic [CNT_W-1:0]  ret_idx;
  logic [PROD_W-1:0] pp_shifted;

  radix4_ret_tracker #(
    .PP_LAT (PP_LAT),
    .CNT_W  (CNT_W)
  ) u_ret_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .issue_i     (pp_issue_o),
    .start_i     (accept),
    .ret_valid_o (ret_valid),
    .ret_idx_o   (ret_idx)
  );

  assign accept     = req_valid_i && req_ready_o;
  // Carry-out of the top partial product above PROD_W is always zero, so truncation is safe.
  assign pp_shifted = PROD_W'(pp_i) << {ret_idx, 1'b0};

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    pp_issue_o  = 1'b0;
    pp_a_o      = '0;
    pp_b_o      = '0;
    rsp_valid_o = 1'b0;
    rsp_prod_o  = '0;
    busy_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        pp_issue_o = 1'b1;
        pp_a_o     = a_q;
        pp_b_o     = digit_sel(MAX_B_W'(b_q), int'(issue_cnt_q));
        busy_o     = 1'b1;
        if (issue_cnt_q == LAST_DIG) state_d = (PP_LAT > 0) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        if (ret_valid && (ret_idx == LAST_DIG)) state_d = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid_o = 1'b1;
        rsp_prod_o  = acc_q;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q         <= req_a_i;
        b_q         <= req_b_i;
        acc_q       <= '0;
        issue_cnt_q <= '0;
      end else begin
        if (state_q == ST_ISSUE) issue_cnt_q <= issue_cnt_q + 1'b1;
        if (ret_valid) acc_q <= acc_q + pp_shifted;
      end
    end
  end

`ifdef RADIX4_MUL_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_ops_o   <= '0;
      perf_stall_o <= '0;
    end else if (state_q == ST_DONE) begin
      if (rsp_ready_i) perf_ops_o <= perf_ops_o + 32'd1;
      else             perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_radix4_mul_seq.sv
// Bench for radix4_mul_seq: three instances (PP_LAT 0/1/3) with a modelled partial-product unit.
module tb_radix4_mul_seq;

  logic       clk;
  logic       rst       [3];
  logic       req_valid [3];
  logic [7:0] req_a     [3];
  logic [7:0] req_b     [3];
  logic       rsp_ready [3];
  wire        req_ready [3];
  wire  [7:0] pp_a      [3];
  wire  [1:0] pp_b      [3];
  wire        pp_issue  [3];
  wire  [9:0] pp_in     [3];
  wire        rsp_valid [3];
  wire [15:0] rsp_prod  [3];
  wire        busy      [3];
`ifdef RADIX4_MUL_PERF_CNT_EN
  wire [31:0] perf_ops   [3];
  wire [31:0] perf_stall [3];
`endif

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_u
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [9:0] pipe_d [4];
    logic [3:0] pipe_v;
    logic [9:0] junk;

    // Partial-product unit model; drives junk whenever no product is due.
    always_ff @(posedge clk) begin
      junk      <= 10'($urandom);
      pipe_d[0] <= 10'(pp_a[g]) * 10'(pp_b[g]);
      pipe_v[0] <= pp_issue[g];
      for (int i = 1; i < 4; i++) begin
        pipe_d[i] <= pipe_d[i-1];
        pipe_v[i] <= pipe_v[i-1];
      end
    end

    if (L == 0) begin : g_comb
      assign pp_in[g] = pp_issue[g] ? 10'(pp_a[g]) * 10'(pp_b[g]) : junk;
    end else begin : g_pipe
      assign pp_in[g] = pipe_v[L-1] ? pipe_d[L-1] : junk;
    end

    radix4_mul_seq #(.A_W(8), .B_W(8), .PP_LAT(L)) dut (
      .clk_i       (clk),
      .rst_i       (rst[g]),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_a_i     (req_a[g]),
      .req_b_i     (req_b[g]),
      .pp_a_o      (pp_a[g]),
      .pp_b_o      (pp_b[g]),
      .pp_issue_o  (pp_issue[g]),
      .pp_i        (pp_in[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready[g]),
      .rsp_prod_o  (rsp_prod[g]),
      .busy_o      (busy[g])
`ifdef RADIX4_MUL_PERF_CNT_EN
      ,
      .perf_ops_o   (perf_ops[g]),
      .perf_stall_o (perf_stall[g])
`endif
    );
  end

  function automatic int lat_of(input int u);
    case (u)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge with the unit back in idle.
  task automatic run_op(input int u, input logic [7:0] a, input logic [7:0] b, input int stall,
                        input bit hold_next, input logic [7:0] na, input logic [7:0] nb);
    int         c;
    int         n_iss;
    bit         got;
    logic [1:0] exp_d;
    logic [15:0] exp_p;
    exp_p = 16'(a) * 16'(b);
    req_valid[u] = 1'b1;
    req_a[u] = a;
    req_b[u] = b;
    checks++;
    if (req_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready u%0d: got %b want 1", u, req_ready[u]);
    end
    @(posedge clk);
    c = 0;
    n_iss = 0;
    got = 0;
    while (!got && c < 40) begin
      @(negedge clk);
      if (c == 0) req_valid[u] = 1'b0;
      if (pp_issue[u] === 1'b1) begin
        exp_d = 2'((b >> (2 * n_iss)) & 8'd3);
        checks++;
        if (pp_b[u] !== exp_d || pp_a[u] !== a || c != n_iss) begin
          errors++;
          $display("FAIL digit u%0d a=%h b=%h #%0d: got pp_b=%0d pp_a=%h cyc=%0d want %0d %h %0d",
                   u, a, b, n_iss, pp_b[u], pp_a[u], c, exp_d, a, n_iss);
        end
        n_iss++;
      end
      if (rsp_valid[u] === 1'b1) got = 1;
      else c++;
    end
    checks++;
    if (!got || c != 4 + lat_of(u)) begin
      errors++;
      $display("FAIL latency u%0d a=%h b=%h: got %0d (valid=%0b) want %0d", u, a, b, c, got, 4 + lat_of(u));
    end
    checks++;
    if (n_iss != 4) begin
      errors++;
      $display("FAIL issue_count u%0d a=%h b=%h: got %0d want 4", u, a, b, n_iss);
    end
    checks++;
    if (rsp_prod[u] !== exp_p) begin
      errors++;
      $display("FAIL product u%0d a=%h b=%h: got %h want %h", u, a, b, rsp_prod[u], exp_p);
    end
    if (hold_next) begin
      req_valid[u] = 1'b1;
      req_a[u] = na;
      req_b[u] = nb;
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid[u] !== 1'b1 || rsp_prod[u] !== exp_p || req_ready[u] !== 1'b0) begin
        errors++;
        $display("FAIL hold u%0d stall %0d: got valid=%b prod=%h ready=%b want 1 %h 0",
                 u, s, rsp_valid[u], rsp_prod[u], req_ready[u], exp_p);
      end
    end
    rsp_ready[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[u] = 1'b0;
    checks++;
    if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1 || busy[u] !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle u%0d: got valid=%b ready=%b busy=%b want 0 1 0",
               u, rsp_valid[u], req_ready[u], busy[u]);
    end
    if (!hold_next) req_valid[u] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int u, input string tag);
    checks++;
    if ({req_ready[u], rsp_valid[u], pp_issue[u], busy[u]} !== 4'b1000 ||
        pp_a[u] !== 8'h00 || pp_b[u] !== 2'd0 || rsp_prod[u] !== 16'h0000) begin
      errors++;
      $display("FAIL %s u%0d: got rdy=%b vld=%b iss=%b busy=%b pp_a=%h pp_b=%0d prod=%h want 1 0 0 0 00 0 0000",
               tag, u, req_ready[u], rsp_valid[u], pp_issue[u], busy[u], pp_a[u], pp_b[u], rsp_prod[u]);
    end
  endtask

  task automatic pulse_reset(input int u);
    @(negedge clk);
    rst[u] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[u] = 1'b0;
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1;
      req_valid[u] = 1'b0;
      req_a[u] = '0;
      req_b[u] = '0;
      rsp_ready[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) check_reset_outputs(u, "reset_state");
`ifdef RADIX4_MUL_PERF_CNT_EN
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (perf_ops[u] !== 32'd0 || perf_stall[u] !== 32'd0) begin
        errors++;
        $display("FAIL perf_reset u%0d: got %0d %0d want 0 0", u, perf_ops[u], perf_stall[u]);
      end
    end
`endif
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;
  endtask

  task automatic test_vectors();
    run_op(1, 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00);
    run_op(1, 8'd13, 8'h9C, 0, 0, 8'h00, 8'h00);
    for (int u = 0; u < 3; u++) begin
      run_op(u, 8'h00, 8'hA7, 0, 0, 8'h00, 8'h00);
      run_op(u, 8'h5B, 8'h00, 0, 0, 8'h00, 8'h00);
      run_op(u, 8'hFF, 8'hFF, 1, 0, 8'h00, 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    run_op(1, 8'hC3, 8'h6E, 7, 1, 8'h2D, 8'hB1);
    run_op(1, 8'h2D, 8'hB1, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic test_abort();
    for (int u = 1; u < 3; u++) begin
      req_valid[u] = 1'b1;
      req_a[u] = 8'hB7;
      req_b[u] = 8'hE6;
      @(posedge clk);
      @(negedge clk);
      req_valid[u] = 1'b0;
      @(negedge clk);
      checks++;
      if (pp_issue[u] !== 1'b1) begin
        errors++;
        $display("FAIL abort_in_issue u%0d: got pp_issue=%b want 1", u, pp_issue[u]);
      end
      rst[u] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs(u, "abort_reset");
      rst[u] = 1'b0;
      run_op(u, 8'd3, 8'd5, 0, 0, 8'h00, 8'h00);
    end
  endtask

  task automatic test_perf();
`ifdef RADIX4_MUL_PERF_CNT_EN
    pulse_reset(1);
    run_op(1, 8'h11, 8'h22, 0, 0, 8'h00, 8'h00);
    run_op(1, 8'h33, 8'h44, 4, 0, 8'h00, 8'h00);
    run_op(1, 8'h55, 8'h66, 0, 0, 8'h00, 8'h00);
    checks++;
    if (perf_ops[1] !== 32'd3 || perf_stall[1] !== 32'd4) begin
      errors++;
      $display("FAIL perf_counts: got ops=%0d stall=%0d want 3 4", perf_ops[1], perf_stall[1]);
    end
`endif
  endtask

  task automatic test_random_sweep();
    for (int u = 0; u < 3; u++) begin
      for (int n = 0; n < 40; n++) begin
        run_op(u, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 0, 8'h00, 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_vectors();
    test_back_to_back();
    test_abort();
    test_perf();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
